fifo_read_pointer_empty: RTL and testbench

Read-side pointer and empty-flag logic for the dual-clock FIFO. It is the counterpart of the write-pointer/full block and lives entirely in the read clock domain. It keeps the binary read address and the Gray read pointer, which is synchronized into the write domain. It takes the already-synchronized Gray write pointer and produces fifo_empty, an occupancy level, an almost-empty flag and a sticky underflow error.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_gray_to_binary.sv | 15 +
 rtl/fifo_read_pointer_empty.sv | 83 ++++++++
 tb/tb_fifo_read_pointer_empty.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// fifo_pkg: shared address-width helper and Gray/binary conversions for the dual-clock FIFO (rev 1.0)
package fifo_pkg;

  // Callers zero-extend to FIFO_MAX_W and cast the result back to their own width;
  // zero upper bits leave the low bits identical to a native-width conversion.
  localparam int FIFO_MAX_W = 32;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic [FIFO_MAX_W-1:0] bin2gray(input logic [FIFO_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FIFO_MAX_W-1:0] gray2bin(input logic [FIFO_MAX_W-1:0] g);
    logic [FIFO_MAX_W-1:0] b;
    b[FIFO_MAX_W-1] = g[FIFO_MAX_W-1];
    for (int i = FIFO_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_gray_to_binary.sv
`default_nettype none
// fifo_gray_to_binary: combinational Gray-to-binary converter of width W (rev 1.0)
module fifo_gray_to_binary
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(FIFO_MAX_W'(gray)));

endmodule
`default_nettype wire

// File: rtl/fifo_read_pointer_empty.sv
`default_nettype none
// fifo_read_pointer_empty: read-domain pointer, empty/almost-empty, level and sticky underflow (rev 1.0)
module fifo_read_pointer_empty
  import fifo_pkg::*;
#(
  parameter int DEPTH                  = 16,
  parameter int ALMOST_EMPTY_THRESHOLD = 2,
  localparam int AW                    = addr_width(DEPTH)
) (
  input  logic          read_clock,
  input  logic          read_reset,
  input  logic          read_enable,
  input  logic [AW:0]   sync_write_pointer,
  input  logic          clear_underflow,
  output logic          fifo_empty,
  output logic          almost_empty,
  output logic [AW:0]   read_level,
  output logic          underflow,
  output logic [AW-1:0] read_address,
  output logic [AW:0]   read_pointer
);

  localparam int          PW        = AW + 1;
  localparam logic [AW:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESHOLD);

  logic [AW:0] read_bin;
  logic [AW:0] read_bin_next;
  logic [AW:0] read_gray_next;
  logic [AW:0] write_bin_sync;
  logic [AW:0] level_next;
  logic        pop;
  logic        empty_next;
  logic        almost_next;
  logic        underflow_next;

  fifo_gray_to_binary #(
    .W (PW)
  ) u_wr_g2b (
    .gray (sync_write_pointer),
    .bin  (write_bin_sync)
  );

  // Qualified against the registered flag, so a pop never reads past the write pointer.
  assign pop            = read_enable & ~fifo_empty;
  assign read_bin_next  = read_bin + PW'(pop);
  assign read_gray_next = PW'(bin2gray(FIFO_MAX_W'(read_bin_next)));

  // Empty and level both derive from the next pointer so level==0 tracks empty exactly.
  assign empty_next  = (read_gray_next == sync_write_pointer);
  assign level_next  = write_bin_sync - read_bin_next;
  assign almost_next = (level_next <= AE_THRESH);

  always_comb begin
    underflow_next = underflow;
    if (read_enable && fifo_empty) begin
      underflow_next = 1'b1;
    end else if (clear_underflow) begin
      underflow_next = 1'b0;
    end
  end

  always_ff @(posedge read_clock) begin
    if (read_reset) begin
      read_bin     <= '0;
      read_pointer <= '0;
      fifo_empty   <= 1'b1;
      almost_empty <= 1'b1;
      read_level   <= '0;
      underflow    <= 1'b0;
    end else begin
      read_bin     <= read_bin_next;
      read_pointer <= read_gray_next;
      fifo_empty   <= empty_next;
      almost_empty <= almost_next;
      read_level   <= level_next;
      underflow    <= underflow_next;
    end
  end

  assign read_address = read_bin[AW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_pointer_empty.sv
`default_nettype none
// tb_fifo_read_pointer_empty: randomized scoreboard bench against a count-based FIFO model (rev 1.0)
module tb_fifo_read_pointer_empty;

  localparam int DEPTH = 16;
  localparam int AE_TH = 2;

  logic       read_clock = 1'b0;
  logic       read_reset = 1'b1;
  logic       read_enable = 1'b0;
  logic [4:0] sync_write_pointer = '0;
  logic       clear_underflow = 1'b0;
  logic       fifo_empty, almost_empty, underflow;
  logic [4:0] read_level, read_pointer;
  logic [3:0] read_address;

  fifo_read_pointer_empty #(
    .DEPTH                  (DEPTH),
    .ALMOST_EMPTY_THRESHOLD (AE_TH)
  ) dut (
    .read_clock         (read_clock),
    .read_reset         (read_reset),
    .read_enable        (read_enable),
    .sync_write_pointer (sync_write_pointer),
    .clear_underflow    (clear_underflow),
    .fifo_empty         (fifo_empty),
    .almost_empty       (almost_empty),
    .read_level         (read_level),
    .underflow          (underflow),
    .read_address       (read_address),
    .read_pointer       (read_pointer)
  );

  always #5 read_clock = ~read_clock;

  typedef struct {
    bit empty;
    bit ae;
    bit uf;
    int level;
    int addr;
    int ptr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: total words written and read; everything else follows from their difference.
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit uf_m   = 0;

  function automatic logic [4:0] gray5(input int x);
    logic [4:0] b;
    b = 5'(x);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit rst, input bit ren, input bit wr, input bit clr);
    exp_t e;
    int   lvl;
    bit   p;
    @(negedge read_clock);
    read_reset      = rst;
    read_enable     = ren;
    clear_underflow = clr;
    if (rst) begin
      wr_cnt = 0;
      rd_cnt = 0;
      uf_m   = 0;
    end else begin
      lvl = wr_cnt - rd_cnt;
      p   = ren && (lvl != 0);
      if (ren && lvl == 0) uf_m = 1;
      else if (clr)        uf_m = 0;
      rd_cnt += int'(p);
      if (wr && (wr_cnt + 1 - rd_cnt) <= DEPTH) wr_cnt++;
    end
    sync_write_pointer = gray5(wr_cnt);
    lvl     = wr_cnt - rd_cnt;
    e.empty = (lvl == 0);
    e.ae    = (lvl <= AE_TH);
    e.uf    = uf_m;
    e.level = lvl;
    e.addr  = rd_cnt % DEPTH;
    e.ptr   = int'(gray5(rd_cnt));
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge read_clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fifo_empty",   int'(fifo_empty),   int'(e.empty));
        check("almost_empty", int'(almost_empty), int'(e.ae));
        check("underflow",    int'(underflow),    int'(e.uf));
        check("read_level",   int'(read_level),   e.level);
        check("read_address", int'(read_address), e.addr);
        check("read_pointer", int'(read_pointer), e.ptr);
      end
    end
  end

  initial begin : stimulus
    // Reset held two cycles with a pop requested.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    // Three writes, idle, then three pops down to empty.
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    // Underflow set, clear, then set-and-clear together.
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    // Random streaming, long enough to wrap the pointer several times.
    for (int i = 0; i < 300; i++) begin
      step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    // Full level: 16 writes from reset, then pop and write together.
    step(1, 0, 0, 0);
    repeat (DEPTH) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    // Drain to level 5, then reset with a pop in flight.
    repeat (11) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    // Random bursts biased toward high occupancy.
    for (int i = 0; i < 200; i++) begin
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    step(0, 0, 0, 0);
    repeat (4) @(negedge read_clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
